// File: rtl/caleido_pkg.sv
// Shared encodings, widths and helpers for the caleidoscope frame-time controller.
package caleido_pkg;

    localparam int unsigned TIME_W  = 16;
    localparam int unsigned TRI_W   = 8;
    localparam int unsigned CONST_W = 24;
    localparam int unsigned SW_W    = 3;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RUN       = 2'd1,
        HOLD      = 2'd2,
        STEP      = 2'd3
    } state_e;

    // Auto-demo modes: bit 0 selects 2x speed, bit 1 selects unlimited time.
    typedef enum logic [1:0] {
        DEMO_1X_LIM = 2'd0,
        DEMO_2X_LIM = 2'd1,
        DEMO_1X_UNL = 2'd2,
        DEMO_2X_UNL = 2'd3
    } demo_mode_e;

    localparam logic [TRI_W-1:0]   TRI_MID    = 8'h80;
    localparam logic [TRI_W-1:0]   TRI_TOP    = 8'hFF;
    localparam logic [CONST_W-1:0] CONST_BASE = 24'h000200;

    // Fold the low time byte into a 0..0x7F triangle.
    function automatic logic [TRI_W-1:0] tri_fold(input logic [TRI_W-1:0] t);
        return (t >= TRI_MID) ? TRI_TOP - t : t;
    endfunction

endpackage

// File: rtl/caleido_time_ctrl_if.sv
// Frame-time controller bus: VBLANK/switch inputs and the per-frame time parameters.
interface caleido_time_ctrl_if;
    import caleido_pkg::*;

    logic               VBLANK;
    logic [SW_W-1:0]    SWITCH;
    logic               STEP_BTN;
    logic [TIME_W-1:0]  TIME;
    logic [TIME_W-1:0]  TIME_TRI;
    logic [CONST_W-1:0] TIME_CONST;
    logic               PARAM_VALID;
    logic [1:0]         STATE_DBG;

    modport master (
        output VBLANK, SWITCH, STEP_BTN,
        input  TIME, TIME_TRI, TIME_CONST, PARAM_VALID, STATE_DBG
    );

    modport slave (
        input  VBLANK, SWITCH, STEP_BTN,
        output TIME, TIME_TRI, TIME_CONST, PARAM_VALID, STATE_DBG
    );

endinterface

// File: rtl/caleido_sync_edge.sv
// N-stage synchroniser for an asynchronous level, plus a registered rising-edge pulse.
module caleido_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              rise_q;

    // Edge is taken on the value entering the last stage so pulse and level stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = rise_q;

endmodule

// File: rtl/caleido_time_ctrl.sv
// Per-frame time sequencer for the caleidoscope generator (hold / step / 2x / unlimited).
// Optional auto-demo mode cycling is enabled with `define CALEIDO_AUTODEMO_EN.
module caleido_time_ctrl
    import caleido_pkg::*;
#(
    parameter int unsigned       SPEED_FAST  = 2,
    parameter logic [TIME_W-1:0] LIMIT_MASK  = 16'h00FF,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       DEMO_FRAMES = 512
) (
    input logic                CLK_50MHz,
    input logic                RESET,
    caleido_time_ctrl_if.slave bus
);

    logic [SW_W-1:0]    sw_sync;
    logic [SW_W-1:0]    sw_rise_unused;
    logic               step_lvl_unused;
    logic               step_rise;
    logic               fe;
    logic               speed2x;
    logic               unlimited;

    state_e             state_q;
    logic [TIME_W-1:0]  time_q;
    logic [TRI_W-1:0]   tri_q;
    logic [CONST_W-1:0] const_q;
    logic [1:0]         pipe_q;
    logic               valid_q;
    logic               vblank_q;
    logic               step_req_q;

    logic [TIME_W-1:0]  inc;
    logic [TIME_W-1:0]  run_sum;
    logic [TIME_W-1:0]  step_sum;
    logic [TIME_W-1:0]  run_next;
    logic [TIME_W-1:0]  step_next;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw_sync
        caleido_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (CLK_50MHz),
            .rst    (RESET),
            .d_i    (bus.SWITCH[i]),
            .q_o    (sw_sync[i]),
            .rise_o (sw_rise_unused[i])
        );
    end

    caleido_sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clk    (CLK_50MHz),
        .rst    (RESET),
        .d_i    (bus.STEP_BTN),
        .q_o    (step_lvl_unused),
        .rise_o (step_rise)
    );

    assign fe = bus.VBLANK & ~vblank_q;

`ifdef CALEIDO_AUTODEMO_EN
    localparam int unsigned DEMO_W = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;

    logic [DEMO_W-1:0] demo_cnt_q;
    demo_mode_e        demo_mode_q;
    logic [1:0]        sw_mode_unused;

    // Demo counter only moves on frames that actually advance time in RUN.
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            demo_cnt_q  <= '0;
            demo_mode_q <= DEMO_1X_LIM;
        end else if (fe && state_q == RUN && !sw_sync[0]) begin
            if (demo_cnt_q == DEMO_W'(DEMO_FRAMES - 1)) begin
                demo_cnt_q  <= '0;
                demo_mode_q <= demo_mode_e'(2'(demo_mode_q + 2'd1));
            end else begin
                demo_cnt_q <= demo_cnt_q + DEMO_W'(1);
            end
        end
    end

    assign sw_mode_unused = sw_sync[2:1];
    assign speed2x        = demo_mode_q[0];
    assign unlimited      = demo_mode_q[1];
`else
    // Frame count is only meaningful in the auto-demo build.
    localparam int unsigned DEMO_FRAMES_UNUSED = DEMO_FRAMES;

    assign speed2x   = sw_sync[1];
    assign unlimited = sw_sync[2];
`endif

    assign inc       = speed2x ? TIME_W'(SPEED_FAST) : TIME_W'(1);
    assign run_sum   = time_q + inc;
    assign step_sum  = time_q + TIME_W'(1);
    assign run_next  = unlimited ? run_sum  : (run_sum & LIMIT_MASK);
    assign step_next = unlimited ? step_sum : (step_sum & LIMIT_MASK);

    // FSM, time counter and the TIME -> TRI -> CONST -> VALID pipeline.
    always_ff @(posedge CLK_50MHz) begin
        if (RESET) begin
            state_q    <= WAIT_SYNC;
            time_q     <= '0;
            tri_q      <= '0;
            const_q    <= CONST_BASE;
            pipe_q     <= '0;
            valid_q    <= 1'b0;
            vblank_q   <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            vblank_q <= bus.VBLANK;
            pipe_q   <= {pipe_q[0], fe};
            valid_q  <= pipe_q[1];
            if (pipe_q[0]) tri_q   <= tri_fold(time_q[TRI_W-1:0]);
            if (pipe_q[1]) const_q <= CONST_BASE - CONST_W'({tri_q, 3'b000});

            // Step requests are only remembered while held.
            if (state_q == HOLD || state_q == STEP) step_req_q <= step_req_q | step_rise;
            else                                    step_req_q <= 1'b0;

            if (fe) begin
                unique case (state_q)
                    WAIT_SYNC: state_q <= sw_sync[0] ? HOLD : RUN;
                    RUN: begin
                        if (sw_sync[0]) state_q <= HOLD;
                        else            time_q  <= run_next;
                    end
                    HOLD: begin
                        if (!sw_sync[0]) begin
                            state_q <= RUN;
                            time_q  <= run_next;
                        end else if (step_req_q) begin
                            state_q    <= STEP;
                            time_q     <= step_next;
                            step_req_q <= 1'b0;
                        end
                    end
                    STEP: state_q <= HOLD;
                    default: state_q <= WAIT_SYNC;
                endcase
            end
        end
    end

    assign bus.TIME        = time_q;
    assign bus.TIME_TRI    = TIME_W'(tri_q);
    assign bus.TIME_CONST  = const_q;
    assign bus.PARAM_VALID = valid_q;
    assign bus.STATE_DBG   = state_q;

endmodule

// File: tb/tb_caleido_time_ctrl.sv
// Self-checking bench for caleido_time_ctrl (default build) using an expected-value scoreboard.
module tb_caleido_time_ctrl;
    import caleido_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    caleido_time_ctrl_if bus_if();

    caleido_time_ctrl dut (
        .CLK_50MHz (clk),
        .RESET     (rst),
        .bus       (bus_if.slave)
    );

    typedef struct packed {
        logic [15:0] t;
        logic [15:0] tr;
        logic [23:0] c;
    } exp_t;

    typedef struct {
        logic [2:0] sw;
        logic       press;
        int         adv;
        logic [1:0] st;
    } hs_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_time;

    function automatic exp_t mk(input logic [15:0] t);
        exp_t       e;
        logic [7:0] lo;
        lo   = t[7:0];
        e.t  = t;
        e.tr = (lo > 8'h7F) ? 16'(8'hFF - lo) : 16'(lo);
        e.c  = 24'h000200 - 24'(e.tr) * 24'd8;
        return e;
    endfunction

    task automatic set_switch(input logic [2:0] sw);
        @(negedge clk);
        bus_if.SWITCH = sw;
        repeat (5) @(negedge clk);
    endtask

    task automatic press_step();
        @(negedge clk);
        bus_if.STEP_BTN = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.STEP_BTN = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // One VBLANK pulse; report strobe latency (0 = never), outputs at the strobe, and strobe width.
    task automatic run_frame(output int lat, output exp_t got, output logic single);
        lat    = 0;
        got    = '0;
        single = 1'b0;
        @(negedge clk);
        bus_if.VBLANK = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus_if.VBLANK = 1'b0;
            if (lat == 0 && bus_if.PARAM_VALID === 1'b1) begin
                lat = k;
                got = {bus_if.TIME, bus_if.TIME_TRI, bus_if.TIME_CONST};
            end else if (lat != 0 && k == lat + 1) begin
                single = (bus_if.PARAM_VALID === 1'b0);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_if.TIME !== 16'h0000) begin n_bad++; $display("FAIL reset_time: got %h expected 0000", bus_if.TIME); end
        n_cmp++; if (bus_if.TIME_TRI !== 16'h0000) begin n_bad++; $display("FAIL reset_tri: got %h expected 0000", bus_if.TIME_TRI); end
        n_cmp++; if (bus_if.TIME_CONST !== 24'h000200) begin n_bad++; $display("FAIL reset_const: got %h expected 000200", bus_if.TIME_CONST); end
        n_cmp++; if (bus_if.PARAM_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus_if.PARAM_VALID); end
        n_cmp++; if (bus_if.STATE_DBG !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", bus_if.STATE_DBG); end
        rst      = 1'b0;
        exp_time = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int   lat;
        exp_t got;
        exp_t e;
        logic single;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) exp_time = exp_time + 16'd1;
            sb_q.push_back(mk(exp_time));
            run_frame(lat, got, single);
            e = sb_q.pop_front();
            n_cmp++; if (lat !== 3 || single !== 1'b1) begin n_bad++; $display("FAIL basic_latency fe%0d: got lat=%0d single=%0b expected lat=3 single=1", i + 1, lat, single); end
            n_cmp++; if (got !== e) begin n_bad++; $display("FAIL basic_values fe%0d: got t=%h tri=%h c=%h expected t=%h tri=%h c=%h", i + 1, got.t, got.tr, got.c, e.t, e.tr, e.c); end
        end
        n_cmp++; if (bus_if.STATE_DBG !== 2'd1) begin n_bad++; $display("FAIL basic_state: got %0d expected 1", bus_if.STATE_DBG); end
    endtask

    // n frames in RUN with the given switches; the bench tracks expected TIME itself.
    task automatic test_advance(input logic [2:0] sw, input int n);
        int          lat;
        exp_t        got;
        exp_t        e;
        logic        single;
        logic [15:0] step;
        set_switch(sw);
        for (int i = 0; i < n; i++) begin
            step     = sw[1] ? 16'd2 : 16'd1;
            exp_time = sw[2] ? exp_time + step : ((exp_time + step) % 16'd256);
            sb_q.push_back(mk(exp_time));
            run_frame(lat, got, single);
            e = sb_q.pop_front();
            n_cmp++; if (lat !== 3 || single !== 1'b1) begin n_bad++; $display("FAIL adv_latency sw=%b i=%0d: got lat=%0d single=%0b expected lat=3 single=1", sw, i, lat, single); end
            n_cmp++; if (got !== e) begin n_bad++; $display("FAIL adv_values sw=%b i=%0d: got t=%h tri=%h c=%h expected t=%h tri=%h c=%h", sw, i, got.t, got.tr, got.c, e.t, e.tr, e.c); end
        end
    endtask

    task automatic test_wrap();
        test_advance(3'b000, 253);
        n_cmp++; if (bus_if.TIME !== 16'h00FF) begin n_bad++; $display("FAIL wrap_pre: got %h expected 00FF", bus_if.TIME); end
        test_advance(3'b000, 1);
        n_cmp++; if (bus_if.TIME !== 16'h0000) begin n_bad++; $display("FAIL wrap_time: got %h expected 0000", bus_if.TIME); end
        n_cmp++; if (bus_if.TIME_TRI !== 16'h0000) begin n_bad++; $display("FAIL wrap_tri: got %h expected 0000", bus_if.TIME_TRI); end
        n_cmp++; if (bus_if.TIME_CONST !== 24'h000200) begin n_bad++; $display("FAIL wrap_const: got %h expected 000200", bus_if.TIME_CONST); end
        test_advance(3'b010, 127);
        test_advance(3'b000, 1);
        n_cmp++; if (bus_if.TIME !== 16'h00FF) begin n_bad++; $display("FAIL unl_pre: got %h expected 00FF", bus_if.TIME); end
        test_advance(3'b100, 1);
        n_cmp++; if (bus_if.TIME !== 16'h0100) begin n_bad++; $display("FAIL unl_time: got %h expected 0100", bus_if.TIME); end
    endtask

    task automatic test_speed2x();
        test_advance(3'b010, 32);
        n_cmp++; if (bus_if.TIME !== 16'h0040) begin n_bad++; $display("FAIL fast_pre: got %h expected 0040", bus_if.TIME); end
        test_advance(3'b010, 1);
        n_cmp++; if (bus_if.TIME !== 16'h0042) begin n_bad++; $display("FAIL fast_time: got %h expected 0042", bus_if.TIME); end
        n_cmp++; if (bus_if.TIME_TRI !== 16'h0042) begin n_bad++; $display("FAIL fast_tri: got %h expected 0042", bus_if.TIME_TRI); end
        n_cmp++; if (bus_if.TIME_CONST !== 24'hFFFFF0) begin n_bad++; $display("FAIL fast_const: got %h expected FFFFF0", bus_if.TIME_CONST); end
    endtask

    task automatic test_hold_step();
        hs_t  seq[$];
        int   lat;
        exp_t got;
        exp_t e;
        logic single;
        for (int i = 0; i < 4; i++) seq.push_back('{3'b001, 1'b0, 0, 2'd2});
        seq.push_back('{3'b001, 1'b1, 1, 2'd3});
        seq.push_back('{3'b001, 1'b0, 0, 2'd2});
        seq.push_back('{3'b000, 1'b0, 1, 2'd1});
        seq.push_back('{3'b001, 1'b1, 0, 2'd2});
        seq.push_back('{3'b001, 1'b0, 0, 2'd2});
        seq.push_back('{3'b000, 1'b0, 1, 2'd1});
        foreach (seq[i]) begin
            if (seq[i].press) press_step();
            set_switch(seq[i].sw);
            exp_time = (exp_time + 16'(seq[i].adv)) % 16'd256;
            sb_q.push_back(mk(exp_time));
            run_frame(lat, got, single);
            e = sb_q.pop_front();
            n_cmp++; if (lat !== 3 || single !== 1'b1) begin n_bad++; $display("FAIL hold_latency row%0d: got lat=%0d single=%0b expected lat=3 single=1", i, lat, single); end
            n_cmp++; if (got !== e) begin n_bad++; $display("FAIL hold_values row%0d: got t=%h tri=%h c=%h expected t=%h tri=%h c=%h", i, got.t, got.tr, got.c, e.t, e.tr, e.c); end
            n_cmp++; if (bus_if.STATE_DBG !== seq[i].st) begin n_bad++; $display("FAIL hold_state row%0d: got %0d expected %0d", i, bus_if.STATE_DBG, seq[i].st); end
        end
    endtask

    task automatic test_reset_mid();
        int   seen;
        int   lat;
        exp_t got;
        exp_t e;
        logic single;
        seen = 0;
        @(negedge clk);
        bus_if.VBLANK = 1'b1;
        @(negedge clk);
        bus_if.VBLANK = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) rst = 1'b0;
            if (bus_if.PARAM_VALID === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_valid: got %0d strobes expected 0", seen); end
        n_cmp++; if (bus_if.TIME !== 16'h0000) begin n_bad++; $display("FAIL abort_time: got %h expected 0000", bus_if.TIME); end
        n_cmp++; if (bus_if.TIME_CONST !== 24'h000200) begin n_bad++; $display("FAIL abort_const: got %h expected 000200", bus_if.TIME_CONST); end
        n_cmp++; if (bus_if.STATE_DBG !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d expected 0", bus_if.STATE_DBG); end
        exp_time = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) exp_time = exp_time + 16'd1;
            sb_q.push_back(mk(exp_time));
            run_frame(lat, got, single);
            e = sb_q.pop_front();
            n_cmp++; if (lat !== 3 || single !== 1'b1) begin n_bad++; $display("FAIL post_latency fe%0d: got lat=%0d single=%0b expected lat=3 single=1", i + 1, lat, single); end
            n_cmp++; if (got !== e) begin n_bad++; $display("FAIL post_values fe%0d: got t=%h tri=%h c=%h expected t=%h tri=%h c=%h", i + 1, got.t, got.tr, got.c, e.t, e.tr, e.c); end
        end
    endtask

    initial begin
        bus_if.VBLANK   = 1'b0;
        bus_if.SWITCH   = 3'b000;
        bus_if.STEP_BTN = 1'b0;
        rst             = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_speed2x();
        test_hold_step();
        set_switch(3'b000);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
